uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
Round-robin scheduler that shares the single uart_transmission engine between two byte producers: port 0 is the Wishbone/ctrl path and port 1 is an auxiliary source such as an echo or debug stream. Each port has its own small byte FIFO. The block hands one byte at a time to the transmitter using the existing tx_start / clear_req / busy handshake. It sits between ctrl (and the auxiliary source) and uart_transmission inside uart.

Parameters:
FIFO_DEPTH, 4, entries per requester FIFO; power of two, minimum 2.
CNT_W, 3, width of the occupancy counters; must equal log2(FIFO_DEPTH)+1.

Ports:
clk  input  1  system clock (wb_clk_i)
rst_n  input  1  synchronous reset, active low
req0_valid  input  1  port 0 byte strobe
req0_data  input  8  port 0 byte
req0_ready  output  1  port 0 FIFO not full
req1_valid  input  1  port 1 byte strobe
req1_data  input  8  port 1 byte
req1_ready  output  1  port 1 FIFO not full
tx_data  output  8  byte presented to transmitter
tx_start  output  1  transmit request level
tx_clear  input  1  transmitter accepted request (clear_req pulse)
tx_busy  input  1  transmitter shifting a frame
grant_id  output  1  source of the byte currently in tx_data
sched_busy  output  1  high when FSM is not in IDLE or either FIFO is non-empty
lvl0, lvl1  output  CNT_W  per-port FIFO occupancy

Behaviour:
Clock and reset:
- One clock, clk. rst_n is synchronous and active low; it is sampled only on the rising edge of clk.

Reset values:
- tx_start=0, tx_data=0, grant_id=0, lvl0=lvl1=0.
- req0_ready=req1_ready=1, sched_busy=0, FSM=IDLE, last_grant=1 so port 0 wins first.
- Reset mid-frame flushes both FIFOs and drops tx_start the next cycle. The transmitter is not aborted; its own reset covers that.

FIFO rules:
- A push happens when reqN_valid && reqN_ready.
- reqN_ready = (lvlN != FIFO_DEPTH), combinational from the registered level.
- A pop happens only on the FSM IDLE->START transition. Push and pop on the same port in the same cycle leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Writes while full are ignored: no push, no corruption.

FSM (3 states):
- IDLE:
  - If either FIFO is non-empty, choose a port.
  - If both are non-empty, choose the one not equal to last_grant.
  - Pop its head into tx_data, set grant_id, go to START.
  - A byte pushed into an empty FIFO at edge n is seen non-empty from cycle n+1. IDLE latches it at edge n+1, and tx_start is high in cycle n+2.
- START:
  - tx_start=1 while tx_data and grant_id are held stable.
  - On tx_clear=1: tx_start=0 at the next edge, last_grant<=grant_id, go to DRAIN.
  - No timeout; the transmitter is guaranteed to clear.
- DRAIN:
  - Wait for tx_busy=0, then go to IDLE.
  - If tx_clear and tx_busy=0 are already both true on entry, DRAIN lasts 1 cycle.
  - The next byte's tx_start therefore never overlaps an active frame.
- Minimum spacing between consecutive tx_start rises is 3 cycles plus the frame time.
- Simultaneous arrival in an idle system: both ports push in the same cycle with last_grant=1, so port 0 is served first and port 1 next.
- Fairness: with both ports backlogged, grants strictly alternate 0,1,0,1. A port never waits more than one other frame.
- tx_clear outside START is ignored.
- tx_busy is only consulted in DRAIN.

Test Plan:
- Reset then a single push req0_data=0x41 → tx_start rises 2 cycles later with tx_data=0x41, grant_id=0. Model clear_req after 1 cycle → tx_start falls next edge. Busy low → sched_busy=0.
- Both ports preloaded: port 0 with 0x10,0x11,0x12 and port 1 with 0x20,0x21,0x22 → transmitter receives 0x10,0x20,0x11,0x21,0x12,0x22 in that order.
- Fill port 1 with 4 bytes while the transmitter model stalls clear_req → req1_ready=0, lvl1=4. A fifth push of 0xFF is dropped and never transmitted.
- Push on port 0 in the same cycle the FSM pops port 0 (lvl0=2) → lvl0 stays 2 and FIFO order is preserved across the pointer wrap (≥6 bytes total).
- Assert rst_n=0 for 1 cycle while in START with 3 bytes queued → next cycle tx_start=0, lvl0=lvl1=0. No further tx_start after reset release.
- Hold tx_busy=1 for 100 cycles after clear_req → FSM stays in DRAIN and no new tx_start appears until tx_busy falls, even with both FIFOs non-empty.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the two byte producers, the scheduler and the
// transmitter: request ports, transmitter handshake and status outputs.
interface uart_tx_sched_if #(
   parameter int CNT_W = 3
);
   logic             req0_valid;
   logic [7:0]       req0_data;
   logic             req0_ready;
   logic             req1_valid;
   logic [7:0]       req1_data;
   logic             req1_ready;
   logic [7:0]       tx_data;
   logic             tx_start;
   logic             tx_clear;
   logic             tx_busy;
   logic             grant_id;
   logic             sched_busy;
   logic [CNT_W-1:0] lvl0;
   logic [CNT_W-1:0] lvl1;

   // Environment side: producers and the transmitter
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, tx_clear, tx_busy,
      input  req0_ready, req1_ready, tx_data, tx_start, grant_id, sched_busy,
             lvl0, lvl1
   );

   // Scheduler side
   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, tx_clear, tx_busy,
      output req0_ready, req1_ready, tx_data, tx_start, grant_id, sched_busy,
             lvl0, lvl1
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between two byte
// producers. Each producer owns a small FIFO; bytes are handed over one at a
// time with the tx_start / tx_clear / tx_busy handshake.
module uart_tx_sched #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_tx_sched_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [7:0]       mem0 [FIFO_DEPTH];
   logic [7:0]       mem1 [FIFO_DEPTH];
   logic [AW-1:0]    wr0, rd0, wr1, rd1;
   logic [CNT_W-1:0] lvl0_q, lvl1_q;
   logic [7:0]       data_q;
   logic             grant_q;
   logic             last_grant;
   logic             ready0, ready1, ne0, ne1;
   logic             push0, push1, pop0, pop1, pick1;

   assign ready0 = (lvl0_q != CNT_W'(FIFO_DEPTH));
   assign ready1 = (lvl1_q != CNT_W'(FIFO_DEPTH));
   assign ne0    = (lvl0_q != '0);
   assign ne1    = (lvl1_q != '0);
   assign push0  = bus.req0_valid && ready0;
   assign push1  = bus.req1_valid && ready1;
   // Port 1 wins when it alone has data, or when both do and port 0 went last
   assign pick1  = ne1 && (!ne0 || !last_grant);
   assign pop0   = (state == IDLE) && ne0 && !pick1;
   assign pop1   = (state == IDLE) && pick1;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state: one byte per pass, never start while a frame is shifting
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (ne0 || ne1)   state_nxt = START;
         START:   if (bus.tx_clear) state_nxt = DRAIN;
         DRAIN:   if (!bus.tx_busy) state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // FSM outputs and status
   always_comb begin
      bus.tx_start   = (state == START);
      bus.sched_busy = (state != IDLE) || ne0 || ne1;
      bus.req0_ready = ready0;
      bus.req1_ready = ready1;
      bus.lvl0       = lvl0_q;
      bus.lvl1       = lvl1_q;
      bus.tx_data    = data_q;
      bus.grant_id   = grant_q;
   end

   // FIFO pointers and occupancy; reset flushes both queues
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr0    <= '0;
         rd0    <= '0;
         wr1    <= '0;
         rd1    <= '0;
         lvl0_q <= '0;
         lvl1_q <= '0;
      end else begin
         if (push0) wr0 <= wr0 + AW'(1);
         if (pop0)  rd0 <= rd0 + AW'(1);
         if (push1) wr1 <= wr1 + AW'(1);
         if (pop1)  rd1 <= rd1 + AW'(1);
         lvl0_q <= lvl0_q + CNT_W'(push0) - CNT_W'(pop0);
         lvl1_q <= lvl1_q + CNT_W'(push1) - CNT_W'(pop1);
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push0) mem0[wr0] <= bus.req0_data;
      if (push1) mem1[wr1] <= bus.req1_data;
   end

   // Byte and source latched on the IDLE->START pop, held through START
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q  <= '0;
         grant_q <= 1'b0;
      end else if (pop0) begin
         data_q  <= mem0[rd0];
         grant_q <= 1'b0;
      end else if (pop1) begin
         data_q  <= mem1[rd1];
         grant_q <= 1'b1;
      end
   end

   // Round-robin memory; starts at 1 so port 0 is served first
   always_ff @(posedge clk) begin
      if (!rst_n)                                last_grant <= 1'b1;
      else if (state == START && bus.tx_clear)   last_grant <= grant_q;
   end
endmodule
